// File: rtl/dly_line_pkg.sv
// Shared definitions for the programmable-delay line: sizes, the delay
// selector type, the controller state encoding and the drain-empty test.
package dly_line_pkg;

    localparam int DLY_WIDTH = 8;
    localparam int DLY_DEPTH = 3;

    typedef logic [1:0] dly_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } dly_state_e;

    // True when no stage at or before the selected tap will hold a valid
    // word after this cycle's shift. v_next[k] is the post-update valid bit
    // of stage k+1. A tap of 0 has no stages in front of it, so it is
    // always empty.
    function automatic logic drain_empty(input dly_sel_t sel,
                                         input logic [DLY_DEPTH-1:0] v_next);
        logic empty;
        empty = 1'b1;
        for (int k = 0; k < DLY_DEPTH; k++) begin
            if ((int'(sel) > k) && v_next[k]) begin
                empty = 1'b0;
            end else begin
                empty = empty;
            end
        end
        return empty;
    endfunction

endpackage

// File: rtl/dly_stage.sv
// One register stage of the delay chain: a data word plus its valid bit.
// The data is always loaded; only the valid bit honours the clear.
module dly_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Shift the word in every cycle; clear drops the valid bit only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_data <= i_data;
            if (i_clr) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= i_valid;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dly_line_ctrl.sv
// Programmable-delay line controller. Words enter through a valid/ready
// handshake and leave 0..DEPTH cycles later through a tap on a register
// chain. A delay change stalls the input, lets words in front of the old
// tap drain out, then clears the chain and switches the tap in one cycle.
module dly_line_ctrl
    import dly_line_pkg::*;
#(
    parameter int WIDTH = DLY_WIDTH,
    parameter int DEPTH = DLY_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_delay,
    output logic             cfg_ready,
    output logic [1:0]       cur_delay,
    output logic             busy
);

    dly_state_e r_state;
    dly_state_e w_state_nxt;
    dly_sel_t   r_cur;
    dly_sel_t   r_pend;
    logic       r_busy;

    logic       w_accept;
    logic       w_cfg_accept;
    logic       w_clr;
    logic       w_drained;

    // Index 0 is the live input (tap for delay 0); index k is stage k.
    logic [WIDTH-1:0] w_sd [DEPTH+1];
    logic [DEPTH:0]   w_sv;

    // Handshakes depend only on state and reset, never on the requests.
    assign in_ready     = (r_state == RUN) && !reset;
    assign cfg_ready    = (r_state == RUN) && !reset;
    assign w_accept     = in_valid && in_ready;
    assign w_cfg_accept = cfg_valid && cfg_ready;
    assign w_clr        = (r_state == SWITCH);

    assign w_sd[0] = in_data;
    assign w_sv[0] = w_accept;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            dly_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_clr   (w_clr),
                .i_data  (w_sd[g]),
                .i_valid (w_sv[g]),
                .o_data  (w_sd[g+1]),
                .o_valid (w_sv[g+1])
            );
        end
    endgenerate

    // The post-update valid of stage k+1 is the current valid of stage k,
    // so the drain test looks one stage upstream of each tap position.
    assign w_drained = drain_empty(r_cur, w_sv[DEPTH-1:0]);

    // Output tap: pick the chain position matching the active delay.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            if (int'(r_cur) == k) begin
                out_valid = w_sv[k];
                out_data  = w_sd[k];
            end else begin
                out_valid = out_valid;
                out_data  = out_data;
            end
        end
    end

    // Next-state decode for the RUN / DRAIN / SWITCH controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (cfg_valid && (cfg_delay != r_cur)) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = SWITCH;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            SWITCH: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Controller registers: state, busy flag, pending and active delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_cur   <= 2'd0;
            r_pend  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != RUN);
            if (w_cfg_accept) begin
                r_pend <= cfg_delay;
            end else begin
                r_pend <= r_pend;
            end
            if (r_state == SWITCH) begin
                r_cur <= r_pend;
            end else begin
                r_cur <= r_cur;
            end
        end
    end

    assign cur_delay = r_cur;
    assign busy      = r_busy;

endmodule
